lenet_frame_streamer: RTL

Synthesizable pixel source that drives the input side of `lenet_top`. A host loads one MAPSIZE×MAPSIZE signed 8-bit image into an internal RAM. On request, the block emits a one-cycle `start` pulse and then streams the image raster-order as a gap-free `valid`/`pixel` stream. It then waits for `layer_done` from the layer pipeline, with a timeout, before it accepts the next frame.

---
 rtl/lenet_frame_streamer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/lenet_frame_streamer.sv
// rtl/lenet_frame_streamer.sv - frame RAM and raster pixel source feeding lenet_top
// Optional build macro: LENET_STREAMER_DBUF_EN selects a ping-pong pair of image banks.
module lenet_frame_streamer #(
    parameter int MAPSIZE = 32,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 3000
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 wr_en,
    input  logic [$clog2(MAPSIZE*MAPSIZE)-1:0]   wr_addr,
    input  logic [DATA_W-1:0]                    wr_data,
    input  logic                                 frame_go,
    input  logic                                 layer_done,
    output logic                                 busy,
    output logic                                 start,
    output logic                                 data_valid_out,
    output logic [DATA_W-1:0]                    pixel_out,
    output logic                                 frame_sent,
    output logic                                 timeout_err
);

    localparam int N  = MAPSIZE * MAPSIZE;
    localparam int AW = $clog2(N);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);
    localparam logic [AW:0]   N_EXT    = (AW + 1)'(N);
    localparam logic [TW-1:0] WAIT_MAX = TW'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_START  = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;
    localparam logic [1:0] S_WAIT   = 2'd3;

    logic [1:0]        state;
    logic [AW-1:0]     pix_cnt;
    logic [TW-1:0]     wait_cnt;
    logic              timeout_q;
    logic [DATA_W-1:0] ram_q;
    logic [AW-1:0]     rd_addr;
    logic              rd_en;
    logic              wr_in_range;
    logic              go_accept;

    assign wr_in_range = ({1'b0, wr_addr} < N_EXT);
    assign go_accept   = (state == S_IDLE) && frame_go;
    assign rd_en       = (state == S_START) || (state == S_STREAM);

    // Read one pixel ahead of the one being presented; saturate at the last index.
    always_comb begin
        rd_addr = '0;
        if (state == S_STREAM && pix_cnt != LAST_IDX) begin
            rd_addr = pix_cnt + 1'b1;
        end else if (state == S_STREAM) begin
            rd_addr = LAST_IDX;
        end
    end

    // Frame sequencer: IDLE -> START -> STREAM -> WAIT_DONE -> IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pix_cnt   <= '0;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (frame_go) begin
                        timeout_q <= 1'b0;
                        pix_cnt   <= '0;
                        state     <= S_START;
                    end
                end
                S_START: begin
                    pix_cnt <= '0;
                    state   <= S_STREAM;
                end
                S_STREAM: begin
                    if (pix_cnt == LAST_IDX) begin
                        wait_cnt <= '0;
                        state    <= S_WAIT;
                    end else begin
                        pix_cnt <= pix_cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (layer_done) begin
                        state <= S_IDLE;
                    end else if (wait_cnt == WAIT_MAX) begin
                        timeout_q <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef LENET_STREAMER_DBUF_EN
    logic                bank_sel;
    logic [DATA_W-1:0]   mem [0:2*N-1];

    // Front-bank pointer flips on every accepted request so the freshly loaded bank streams.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_sel <= 1'b0;
        end else if (go_accept) begin
            bank_sel <= ~bank_sel;
        end
    end

    // Host always fills the back bank; the sequencer reads the front bank.
    always_ff @(posedge clk) begin
        if (wr_en && wr_in_range) begin
            mem[{~bank_sel, wr_addr}] <= wr_data;
        end
        if (rd_en) begin
            ram_q <= mem[{bank_sel, rd_addr}];
        end
    end
`else
    logic [DATA_W-1:0]   mem [0:N-1];

    // Single bank: host writes only land while the streamer is idle.
    always_ff @(posedge clk) begin
        if (wr_en && wr_in_range && !busy) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            ram_q <= mem[rd_addr];
        end
    end
`endif

    assign busy           = (state != S_IDLE);
    assign start          = (state == S_START);
    assign data_valid_out = (state == S_STREAM);
    assign pixel_out      = data_valid_out ? ram_q : '0;
    assign frame_sent     = (state == S_WAIT) && (wait_cnt == '0);
    assign timeout_err    = timeout_q;

endmodule
